// File: rtl/mcu_frame_router_if.sv
// MCU-side SPI byte stream plus the fan-out bus to the command targets.
// The slave modport is the router's view; master is the surrounding environment.
interface mcu_frame_router_if #(
   parameter int unsigned NTARGETS = 4
);
   logic                    spi_strobe;
   logic                    spi_start;
   logic [7:0]              spi_din;
   logic [7:0]              spi_dout;
   logic [NTARGETS-1:0]     tgt_strobe;
   logic                    tgt_start;
   logic [7:0]              tgt_din;
   logic [8*NTARGETS-1:0]   tgt_dout;
   logic [NTARGETS-1:0]     tgt_int;
   logic                    int_out_n;

   modport slave (
      input  spi_strobe, spi_start, spi_din, tgt_dout, tgt_int,
      output spi_dout, tgt_strobe, tgt_start, tgt_din, int_out_n
   );

   modport master (
      output spi_strobe, spi_start, spi_din, tgt_dout, tgt_int,
      input  spi_dout, tgt_strobe, tgt_start, tgt_din, int_out_n
   );
endinterface

// File: rtl/mcu_frame_router.sv
// Routes MCU SPI frames to one target selected by the frame's first byte,
// returns that target's reply byte, and merges masked target interrupts.
module mcu_frame_router #(
   parameter int unsigned NTARGETS = 4,
   parameter logic [7:0]  CTRL_ID  = 8'hFE
) (
   input  logic              clk,
   input  logic              reset_n,
   mcu_frame_router_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FWD_FIRST, FWD, CTRL, DISCARD} state_t;

   localparam logic [7:0] NT8 = 8'(NTARGETS);

   state_t              state, state_nxt;
   logic [7:0]          sel, sel_nxt;
   logic [1:0]          cidx, cidx_nxt;
   logic [NTARGETS-1:0] mask, mask_nxt;
   logic [NTARGETS-1:0] pending;
   logic [7:0]          err_cnt, err_nxt;
   logic [NTARGETS-1:0] strobe_q, strobe_nxt;
   logic                start_q, start_nxt;
   logic [7:0]          din_q, din_nxt;
   logic [7:0]          dout_q, dout_nxt;
   logic                int_n_q;
   logic [7:0]          reply;
   logic                frame_start;
   logic                data_byte;

   assign frame_start = bus.spi_strobe & bus.spi_start;
   assign data_byte   = bus.spi_strobe & ~bus.spi_start;

   // Compare-based select keeps out-of-range sel values from indexing past the bus.
   always_comb begin
      reply = '0;
      for (int unsigned k = 0; k < NTARGETS; k++) begin
         if (sel == 8'(k)) reply = bus.tgt_dout[8*k +: 8];
      end
   end

   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      cidx_nxt   = cidx;
      mask_nxt   = mask;
      err_nxt    = err_cnt;
      strobe_nxt = '0;
      start_nxt  = start_q;
      din_nxt    = din_q;
      dout_nxt   = 8'h00;

      if (frame_start) begin
         sel_nxt = bus.spi_din;
         if (bus.spi_din < NT8) begin
            state_nxt = FWD_FIRST;
         end else if (bus.spi_din == CTRL_ID) begin
            state_nxt = CTRL;
            cidx_nxt  = '0;
         end else begin
            state_nxt = DISCARD;
            if (err_cnt != '1) err_nxt = err_cnt + 8'd1;
         end
      end else if (data_byte) begin
         case (state)
            FWD_FIRST, FWD: begin
               for (int unsigned k = 0; k < NTARGETS; k++) begin
                  if (sel == 8'(k)) strobe_nxt[k] = 1'b1;
               end
               start_nxt = (state == FWD_FIRST);
               din_nxt   = bus.spi_din;
               state_nxt = FWD;
            end
            CTRL: begin
               if (cidx == 2'd0) mask_nxt = bus.spi_din[NTARGETS-1:0];
               if (cidx == 2'd1 && bus.spi_din[0]) err_nxt = '0;
               if (cidx != 2'd3) cidx_nxt = cidx + 2'd1;
            end
            default: ;
         endcase
      end

      // Reply reflects the state held this cycle, not the byte just arriving.
      case (state)
         FWD_FIRST, FWD: dout_nxt = reply;
         CTRL: begin
            if (cidx == 2'd0)      dout_nxt = 8'(pending);
            else if (cidx == 2'd1) dout_nxt = err_cnt;
            else                   dout_nxt = 8'h00;
         end
         DISCARD: dout_nxt = 8'hFF;
         default: dout_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         sel      <= '0;
         cidx     <= '0;
         mask     <= '1;
         err_cnt  <= '0;
         strobe_q <= '0;
         start_q  <= 1'b0;
         din_q    <= '0;
         dout_q   <= '0;
         pending  <= '0;
         int_n_q  <= 1'b1;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         cidx     <= cidx_nxt;
         mask     <= mask_nxt;
         err_cnt  <= err_nxt;
         strobe_q <= strobe_nxt;
         start_q  <= start_nxt;
         din_q    <= din_nxt;
         dout_q   <= dout_nxt;
         pending  <= bus.tgt_int & mask;
         int_n_q  <= ~|pending;
      end
   end

   assign bus.spi_dout   = dout_q;
   assign bus.tgt_strobe = strobe_q;
   assign bus.tgt_start  = start_q;
   assign bus.tgt_din    = din_q;
   assign bus.int_out_n  = int_n_q;
endmodule

// File: tb/tb_mcu_frame_router.sv
// Directed bench for mcu_frame_router: forwarded bytes are scoreboarded,
// reply bytes and the interrupt line are checked against hand-derived values.
module tb_mcu_frame_router;
   localparam int unsigned NT = 4;

   typedef struct packed {
      logic [NT-1:0] strobe;
      logic          start;
      logic [7:0]    din;
   } fwd_t;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;
   fwd_t exp_q[$];
   fwd_t mon_e;

   always #5 clk = ~clk;

   mcu_frame_router_if #(.NTARGETS(NT)) bus ();

   mcu_frame_router #(.NTARGETS(NT), .CTRL_ID(8'hFE)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic send(input logic st, input logic [7:0] d);
      @(negedge clk);
      bus.spi_strobe = 1'b1;
      bus.spi_start  = st;
      bus.spi_din    = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.spi_strobe = 1'b0;
         bus.spi_start  = 1'b0;
      end
   endtask

   task automatic expect_fwd(input logic [NT-1:0] s, input logic st, input logic [7:0] d);
      exp_q.push_back('{strobe: s, start: st, din: d});
   endtask

   // Every forwarded strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.tgt_strobe !== '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: got strobe=%b start=%b din=%h, expected no strobe",
                     bus.tgt_strobe, bus.tgt_start, bus.tgt_din);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.tgt_strobe, bus.tgt_start, bus.tgt_din} !== mon_e) begin
               errors++;
               $display("FAIL fwd_byte: got strobe=%b start=%b din=%h, expected strobe=%b start=%b din=%h",
                        bus.tgt_strobe, bus.tgt_start, bus.tgt_din,
                        mon_e.strobe, mon_e.start, mon_e.din);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n        = 1'b0;
      bus.spi_strobe = 1'b0;
      bus.spi_start  = 1'b0;
      bus.spi_din    = 8'h00;
      bus.tgt_dout   = {8'h00, 8'h00, 8'h33, 8'h00};
      bus.tgt_int    = '0;
      #12;
      chk8("rst_spi_dout", bus.spi_dout, 8'h00);
      chk8("rst_tgt_strobe", 8'(bus.tgt_strobe), 8'h00);
      chk1("rst_tgt_start", bus.tgt_start, 1'b0);
      chk8("rst_tgt_din", bus.tgt_din, 8'h00);
      chk1("rst_int_out_n", bus.int_out_n, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Frame to target 1; its reply changes during the strobe cycle of byte 05.
      send(1'b1, 8'h01);
      expect_fwd(4'b0010, 1'b1, 8'h05);
      send(1'b0, 8'h05);
      idle(1);
      chk8("reply_before", bus.spi_dout, 8'h33);
      bus.tgt_dout[15:8] = 8'h5C;
      idle(1);
      chk8("reply_two_cycles", bus.spi_dout, 8'h5C);
      expect_fwd(4'b0010, 1'b0, 8'hAA);
      send(1'b0, 8'hAA);
      expect_fwd(4'b0010, 1'b0, 8'hBB);
      send(1'b0, 8'hBB);
      idle(3);
      chk8("hold_tgt_din", bus.tgt_din, 8'hBB);
      chk1("hold_tgt_start", bus.tgt_start, 1'b0);

      // Unknown target id: bytes dropped, reply FF, error counted.
      send(1'b1, 8'h07);
      send(1'b0, 8'h12);
      send(1'b0, 8'h34);
      idle(2);
      chk8("discard_reply", bus.spi_dout, 8'hFF);

      // Control frame with reset mask (all ones) exposes pending = 0011.
      bus.tgt_int = 4'b0011;
      idle(3);
      chk1("int_reset_mask", bus.int_out_n, 1'b0);
      send(1'b1, 8'hFE);
      idle(2);
      chk8("ctrl_pending", bus.spi_dout, 8'h03);
      send(1'b0, 8'h00);
      idle(2);
      chk8("ctrl_err_cnt", bus.spi_dout, 8'h01);
      chk1("mask_clear_lag", bus.int_out_n, 1'b0);
      idle(1);
      chk1("mask_clear_int", bus.int_out_n, 1'b1);
      send(1'b0, 8'h01);
      idle(2);
      chk8("ctrl_idx2", bus.spi_dout, 8'h00);

      // New mask 0100 with tgt_int 0101; err_cnt was cleared by the previous frame.
      bus.tgt_int = 4'b0101;
      send(1'b1, 8'hFE);
      idle(2);
      chk8("ctrl_pending_masked", bus.spi_dout, 8'h00);
      chk1("int_masked_off", bus.int_out_n, 1'b1);
      send(1'b0, 8'h04);
      idle(2);
      chk8("err_cnt_cleared", bus.spi_dout, 8'h00);
      chk1("mask_set_lag", bus.int_out_n, 1'b1);
      idle(1);
      chk1("mask_set_int", bus.int_out_n, 1'b0);
      bus.tgt_int = 4'b0001;
      idle(1);
      chk1("int_release_lag", bus.int_out_n, 1'b0);
      idle(1);
      chk1("int_release", bus.int_out_n, 1'b1);

      // Back-to-back bytes with a restart mid-frame.
      expect_fwd(4'b0100, 1'b1, 8'h11);
      expect_fwd(4'b0001, 1'b1, 8'h22);
      expect_fwd(4'b0001, 1'b0, 8'h33);
      send(1'b1, 8'h02);
      send(1'b0, 8'h11);
      send(1'b1, 8'h00);
      send(1'b0, 8'h22);
      send(1'b0, 8'h33);
      idle(3);

      // Asynchronous reset between payload bytes.
      bus.tgt_int = '0;
      expect_fwd(4'b1000, 1'b1, 8'h44);
      send(1'b1, 8'h03);
      send(1'b0, 8'h44);
      idle(2);
      #2 reset_n = 1'b0;
      #1;
      chk8("midrst_tgt_din", bus.tgt_din, 8'h00);
      chk8("midrst_strobe", 8'(bus.tgt_strobe), 8'h00);
      reset_n = 1'b1;
      send(1'b0, 8'h55);
      idle(3);
      chk8("post_rst_reply", bus.spi_dout, 8'h00);
      chk1("post_rst_start", bus.tgt_start, 1'b0);
      bus.tgt_int = 4'b1000;
      idle(2);
      chk1("post_rst_mask", bus.int_out_n, 1'b0);

      idle(2);
      chk8("scoreboard_drained", 8'(exp_q.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
